// File: rtl/spi_mem_pkg.sv
// Shared constants for the SPI-to-RAM bridge: command byte layout and FSM state codes.
// Kept in one package so the bridge and any future siblings agree on the encoding.
package spi_mem_pkg;

  localparam int BYTE_W       = 8;
  localparam int CMD_READ_BIT = 7;
  localparam int CMD_RSVD_MSB = 6;
  localparam int CMD_RSVD_LSB = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_WDATA   = 3'd2;
  localparam logic [2:0] S_WSTROBE = 3'd3;
  localparam logic [2:0] S_RFETCH  = 3'd4;
  localparam logic [2:0] S_RWAIT   = 3'd5;
  localparam logic [2:0] S_RSHIFT  = 3'd6;
  localparam logic [2:0] S_ERR     = 3'd7;

  function automatic logic cmd_rsvd_ok(input logic [BYTE_W-1:0] cmd);
    return cmd[CMD_RSVD_MSB:CMD_RSVD_LSB] == '0;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage synchronizer for an asynchronous pin, with single-cycle rise/fall pulses
// derived from the synchronized level. STAGES must be at least 2.
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // NOTE: non-blocking assignments make each stage capture its neighbour's old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], pin};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_mem_bridge.sv
// SPI mode-0 slave that turns command/data bytes into strobes for a 16-byte RAM macro,
// with auto-incrementing write and prefetching read bursts.
module spi_mem_bridge
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BYTE_W-1:0] mem_wdata,
  output logic              mem_lr_n,
  output logic              mem_ce_n,
  input  logic [BYTE_W-1:0] mem_rdata,
  output logic              busy
);

  logic sclk_rise, sclk_fall, unused_sclk_level;
  logic cs_level, cs_fall, unused_cs_rise;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_level;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .pin(sclk),
    .level(unused_sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  // Chip select resets to the deselected level so reset release is not a false select.
  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .pin(cs_n),
    .level(cs_level), .rise(unused_cs_rise), .fall(cs_fall)
  );

  // Same depth as sclk so the data bit is aligned with the detected rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_sync <= '0;
    else        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_level = mosi_sync[SYNC_STAGES-1];

  logic [2:0]        state;
  logic [3:0]        bit_cnt;
  logic [BYTE_W-1:0] rx_shift, tx_shift, rx_next;

  assign rx_next = {rx_shift[BYTE_W-2:0], mosi_level};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (cs_level && state != S_IDLE && state != S_WSTROBE) begin
      // Deselect drops any partial byte; a strobe already issued is allowed to finish.
      state    <= S_IDLE;
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cs_fall) begin
            state    <= S_CMD;
            bit_cnt  <= '0;
            rx_shift <= '0;
          end
        end
        S_CMD: begin
          if (sclk_rise) begin
            rx_shift <= rx_next;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              if (!cmd_rsvd_ok(rx_next)) begin
                state <= S_ERR;
              end else begin
                mem_addr <= rx_next[ADDR_W-1:0];
                state    <= rx_next[CMD_READ_BIT] ? S_RFETCH : S_WDATA;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        S_WDATA: begin
          if (sclk_rise) begin
            rx_shift <= rx_next;
            if (bit_cnt == 4'd7) begin
              bit_cnt   <= '0;
              mem_wdata <= rx_next;
              state     <= S_WSTROBE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        S_WSTROBE: begin
          mem_addr <= mem_addr + 1'b1;
          state    <= cs_level ? S_IDLE : S_WDATA;
        end
        S_RFETCH: state <= S_RWAIT;
        S_RWAIT: begin
          tx_shift <= mem_rdata;
          bit_cnt  <= '0;
          state    <= S_RSHIFT;
        end
        S_RSHIFT: begin
          // The falling edge that closes the previous byte arrives with bit_cnt == 0 and is ignored.
          if (sclk_rise) begin
            bit_cnt <= bit_cnt + 4'd1;
          end else if (sclk_fall && bit_cnt != 4'd0) begin
            tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
            if (bit_cnt == 4'd8) begin
              mem_addr <= mem_addr + 1'b1;
              state    <= S_RFETCH;
            end
          end
        end
        default: state <= state;
      endcase
    end
  end

  // NOTE: outputs are continuous decodes of registered state, so no latch can form.
  assign busy     = (state != S_IDLE);
  assign mem_lr_n = (state != S_WSTROBE);
  assign mem_ce_n = (state != S_RFETCH);
  assign miso_oe  = busy && (state != S_CMD);
  assign miso     = (state == S_RSHIFT) && tx_shift[BYTE_W-1];

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Bench for spi_mem_bridge: a SPI master task, a registered-read RAM model, and a
// transaction-level reference memory that predicts writes and read-back bytes.
module tb_spi_mem_bridge;

  localparam int ADDR_W      = 4;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic miso, miso_oe, mem_lr_n, mem_ce_n, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_mem_bridge #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_lr_n(mem_lr_n), .mem_ce_n(mem_ce_n), .mem_rdata(mem_rdata), .busy(busy)
  );

  logic [7:0]  ram [16];
  logic [7:0]  ref_mem [16];
  logic [11:0] wq [$];
  int ce_cnt = 0;
  int overlap = 0;
  int miso_hi = 0;
  logic       rd_pend = 1'b0;
  logic [3:0] rd_addr = 4'h0;

  // RAM macro model (read data appears one clk after the enable) and bus monitor.
  always @(negedge clk) begin
    if (rd_pend) begin
      mem_rdata = ram[rd_addr];
      rd_pend = 1'b0;
    end
    if (rst_n) begin
      if (!mem_lr_n) begin
        wq.push_back({mem_addr, mem_wdata});
        ram[mem_addr] = mem_wdata;
      end
      if (!mem_ce_n && mem_lr_n) begin
        rd_pend = 1'b1;
        rd_addr = mem_addr;
      end
      if (!mem_ce_n) ce_cnt++;
      if (!mem_ce_n && !mem_lr_n) overlap++;
      if (miso) miso_hi++;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      rx = {rx[6:0], miso};
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  int wbase, ce0, ov0, mh0;

  task automatic snap();
    wbase = wq.size();
    ce0 = ce_cnt;
    ov0 = overlap;
    mh0 = miso_hi;
  endtask

  task automatic run_txn(input int n, input logic [3:0][7:0] b, output logic [3:0][7:0] rx);
    logic [7:0] r;
    rx = '0;
    snap();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      spi_bits(b[k], 8, r);
      rx[k] = r;
    end
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (3 * HALF) @(negedge clk);
  endtask

  // Reference: command decides the kind; byte k (k >= 1) maps to address (start + k - 1) mod 16.
  task automatic model_check(input string tag, input int n, input logic [3:0][7:0] b,
                             input logic [3:0][7:0] rx);
    logic [7:0]  cmd;
    int          start, a, nw, nce;
    logic [11:0] got;
    cmd = b[0];
    start = int'(cmd[3:0]);
    nw = wq.size() - wbase;
    nce = ce_cnt - ce0;
    check({tag, "_overlap"}, overlap - ov0, 0);
    if (cmd[6:4] != 3'b000) begin
      check({tag, "_err_writes"}, nw, 0);
      check({tag, "_err_reads"}, nce, 0);
      check({tag, "_err_miso"}, miso_hi - mh0, 0);
    end else if (cmd[7]) begin
      check({tag, "_rd_writes"}, nw, 0);
      check({tag, "_rd_ce_range"}, (nce >= n - 1 && nce <= n) ? 1 : 0, 1);
      for (int k = 1; k < n; k++) begin
        a = (start + k - 1) % 16;
        check($sformatf("%s_rd%0d", tag, k), rx[k], ref_mem[a]);
      end
    end else begin
      check({tag, "_wr_count"}, nw, n - 1);
      check({tag, "_wr_reads"}, nce, 0);
      for (int k = 1; k < n; k++) begin
        a = (start + k - 1) % 16;
        got = (wbase + k - 1 < wq.size()) ? wq[wbase + k - 1] : 12'hxxx;
        check($sformatf("%s_wr%0d", tag, k), got, {a[3:0], b[k]});
        ref_mem[a] = b[k];
      end
    end
  endtask

  typedef struct {
    int              n;
    logic [3:0][7:0] b;
    int              exp_wr;
    logic [2:0][7:0] exp_rd;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [7:0] b0, b1, b2, b3, input int ew,
                              input logic [7:0] r1, r2, r3);
    vec_t v;
    v.n = n;
    v.b = {b3, b2, b1, b0};
    v.exp_wr = ew;
    v.exp_rd = {r3, r2, r1};
    return v;
  endfunction

  vec_t vecs [5];
  logic [3:0][7:0] rx;
  logic [3:0][7:0] tb_b;
  logic [7:0] dummy;
  logic found;

  initial begin
    vecs[0] = mk(2, 8'h03, 8'hA5, 8'h00, 8'h00, 1, 8'h00, 8'h00, 8'h00);
    vecs[1] = mk(4, 8'h0E, 8'h11, 8'h22, 8'h33, 3, 8'h00, 8'h00, 8'h00);
    vecs[2] = mk(4, 8'h8E, 8'h00, 8'h00, 8'h00, 0, 8'h11, 8'h22, 8'h33);
    vecs[3] = mk(2, 8'h43, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00);
    vecs[4] = mk(2, 8'h03, 8'h5A, 8'h00, 8'h00, 1, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 16; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end

    // Reset state
    repeat (4) @(negedge clk);
    check("reset_outputs", {miso, miso_oe, busy, mem_lr_n, mem_ce_n, mem_addr, mem_wdata},
          {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 8'h00});
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Asynchronous reset in the middle of a write burst
    snap();
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(8'h05, 8, dummy);
    spi_bits(8'hC3, 5, dummy);
    check("midreset_busy_before", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("midreset_outputs", {miso, miso_oe, busy, mem_lr_n, mem_ce_n, mem_addr, mem_wdata},
             {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    spi_bits(8'h00, 3, dummy);
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (3 * HALF) @(negedge clk);
    check("midreset_no_write", wq.size() - wbase, 0);
    check("midreset_idle", busy, 1'b0);

    // Directed vectors
    for (int v = 0; v < 5; v++) begin
      run_txn(vecs[v].n, vecs[v].b, rx);
      check($sformatf("vec%0d_wr_total", v), wq.size() - wbase, vecs[v].exp_wr);
      if (vecs[v].b[0][7])
        for (int k = 1; k < vecs[v].n; k++)
          check($sformatf("vec%0d_tbl_rd%0d", v, k), rx[k], vecs[v].exp_rd[k-1]);
      model_check($sformatf("vec%0d", v), vecs[v].n, vecs[v].b, rx);
    end

    // Abort after 5 bits of the data byte
    snap();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(8'h07, 8, dummy);
    spi_bits(8'h99, 5, dummy);
    check("abort_busy_before", busy, 1'b1);
    cs_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < SYNC_STAGES + 2 && !found; i++) begin
      @(negedge clk);
      if (!busy) found = 1'b1;
    end
    check("abort_busy_falls", found, 1'b1);
    repeat (3 * HALF) @(negedge clk);
    check("abort_no_write", wq.size() - wbase, 0);

    // Randomized transactions against the reference memory
    for (int t = 0; t < 24; t++) begin
      int kind, n;
      logic [3:0] a;
      logic [2:0] rs;
      kind = $urandom_range(0, 3);
      a = 4'($urandom_range(0, 15));
      rs = 3'($urandom_range(1, 7));
      n = $urandom_range(2, 4);
      tb_b = {8'($urandom), 8'($urandom), 8'($urandom), 8'h00};
      case (kind)
        0, 1:    tb_b[0] = {4'b0000, a};
        2:       tb_b[0] = {4'b1000, a};
        default: tb_b[0] = {1'($urandom_range(0, 1)), rs, a};
      endcase
      run_txn(n, tb_b, rx);
      model_check($sformatf("rnd%0d", t), n, tb_b, rx);
    end

    for (int i = 0; i < 16; i++) check($sformatf("final_ram%0d", i), ram[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
